// File: rtl/miniproc_control_pkg.sv
// Shared definitions for the mini processor controller: opcodes, FSM states,
// register indices and datapath widths.
package miniproc_control_pkg;

  localparam int WORD_W = 4;
  localparam int PC_W   = 3;
  localparam int OP_W   = 2;
  localparam int REG_W  = 2;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_MOV  = 2'b10,
    OP_HALT = 2'b11
  } opcode_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_FETCH  = 3'd2,
    S_DECODE = 3'd3,
    S_EXEC   = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  localparam logic [REG_W-1:0] R1 = 2'd1;
  localparam logic [REG_W-1:0] R2 = 2'd2;
  localparam logic [REG_W-1:0] R3 = 2'd3;

  localparam logic [PC_W-1:0] LAST_ADR = 3'd7;

endpackage

// File: rtl/miniproc_control_if.sv
// Host control plus instruction/data memory buses of the controller.
// master = controller side, slave = host and memories.
interface miniproc_control_if;
  import miniproc_control_pkg::*;

  logic              load;
  logic [OP_W-1:0]   load_data;
  logic              start;
  logic [PC_W-1:0]   i_adr;
  logic              i_w_e_n;
  logic [OP_W-1:0]   i_data_w;
  logic [OP_W-1:0]   i_out;
  logic [REG_W-1:0]  adr_r_a;
  logic [REG_W-1:0]  adr_r_b;
  logic [WORD_W-1:0] out_a;
  logic [WORD_W-1:0] out_b;
  logic              d_w_e_n;
  logic [REG_W-1:0]  adr_w;
  logic [WORD_W-1:0] data_w;
  logic [PC_W-1:0]   pc;
  logic              carry;
  logic              busy;
  logic              done;

  modport master (
    input  load, load_data, start, i_out, out_a, out_b,
    output i_adr, i_w_e_n, i_data_w, adr_r_a, adr_r_b,
           d_w_e_n, adr_w, data_w, pc, carry, busy, done
  );

  modport slave (
    output load, load_data, start, i_out, out_a, out_b,
    input  i_adr, i_w_e_n, i_data_w, adr_r_a, adr_r_b,
           d_w_e_n, adr_w, data_w, pc, carry, busy, done
  );

endinterface

// File: rtl/miniproc_control_mini_alu.sv
// Combinational ALU: ADD/SUB with carry-or-borrow out, MOV passes operand a
// through and keeps the incoming carry.
module mini_alu
  import miniproc_control_pkg::*;
#(
  parameter int DATA_W = WORD_W
) (
  input  opcode_e           op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              carry_in,
  output logic [DATA_W-1:0] result,
  output logic              carry_out
);

  // Top bit of the extended difference is the borrow, i.e. a < b.
  function automatic logic [DATA_W:0] add_ext(input logic [DATA_W-1:0] x,
                                              input logic [DATA_W-1:0] y);
    return {1'b0, x} + {1'b0, y};
  endfunction

  function automatic logic [DATA_W:0] sub_ext(input logic [DATA_W-1:0] x,
                                              input logic [DATA_W-1:0] y);
    return {1'b0, x} - {1'b0, y};
  endfunction

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  always_comb begin
    sum       = add_ext(a, b);
    diff      = sub_ext(a, b);
    result    = '0;
    carry_out = carry_in;
    case (op)
      OP_ADD: begin
        result    = sum[DATA_W-1:0];
        carry_out = sum[DATA_W];
      end
      OP_SUB: begin
        result    = diff[DATA_W-1:0];
        carry_out = diff[DATA_W];
      end
      OP_MOV:  result = a;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/miniproc_control.sv
// Mini processor controller: program load, FETCH/DECODE/EXEC sequencing,
// program counter and carry flag; arithmetic lives in mini_alu.
module miniproc_control
  import miniproc_control_pkg::*;
(
  input logic                clock,
  input logic                reset,
  miniproc_control_if.master bus
);

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [PC_W-1:0]   ld_cnt_q, ld_cnt_d;
  opcode_e           opcode_q, opcode_d;
  logic              carry_q, carry_d;
  logic [WORD_W-1:0] alu_result;
  logic              alu_carry;

  mini_alu #(.DATA_W(WORD_W)) u_alu (
    .op        (opcode_q),
    .a         (bus.out_a),
    .b         (bus.out_b),
    .carry_in  (carry_q),
    .result    (alu_result),
    .carry_out (alu_carry)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ld_cnt_d     = ld_cnt_q;
    opcode_d     = opcode_q;
    carry_d      = carry_q;
    bus.i_adr    = '0;
    bus.i_w_e_n  = 1'b1;
    bus.i_data_w = '0;
    bus.adr_r_a  = '0;
    bus.adr_r_b  = '0;
    bus.d_w_e_n  = 1'b1;
    bus.adr_w    = '0;
    bus.data_w   = '0;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (bus.load) begin
          state_d  = S_LOAD;
          ld_cnt_d = '0;
        end else if (bus.start) begin
          state_d = S_FETCH;
          pc_d    = '0;
        end
      end
      // Write strobes are masked by reset so a reset edge never commits a write.
      S_LOAD: begin
        bus.i_adr    = ld_cnt_q;
        bus.i_data_w = bus.load_data;
        bus.i_w_e_n  = reset;
        ld_cnt_d     = ld_cnt_q + 3'd1;
        if (!bus.load || ld_cnt_q == LAST_ADR) state_d = S_IDLE;
      end
      S_FETCH: begin
        bus.i_adr = pc_q;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        bus.i_adr = pc_q;
        opcode_d  = opcode_e'(bus.i_out);
        state_d   = (opcode_e'(bus.i_out) == OP_HALT) ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        case (opcode_q)
          OP_ADD, OP_SUB: begin
            bus.adr_r_a = R1;
            bus.adr_r_b = R2;
          end
          OP_MOV: begin
            bus.adr_r_a = R3;
            bus.adr_r_b = R3;
          end
          default: ;
        endcase
        bus.d_w_e_n = reset;
        bus.adr_w   = (opcode_q == OP_MOV) ? R1 : R3;
        bus.data_w  = alu_result;
        carry_d     = alu_carry;
        pc_d        = pc_q + 3'd1;
        state_d     = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
    bus.pc    = pc_q;
    bus.carry = carry_q;
    bus.busy  = (state_q == S_FETCH) || (state_q == S_DECODE) || (state_q == S_EXEC);
    bus.done  = (state_q == S_HALT);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      ld_cnt_q <= '0;
      opcode_q <= OP_ADD;
      carry_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ld_cnt_q <= ld_cnt_d;
      opcode_q <= opcode_d;
      carry_q  <= carry_d;
    end
  end

endmodule

// File: tb/tb_miniproc_control.sv
// Bench for miniproc_control: memory models, a write scoreboard fed by a
// small reference model, and directed load/run/reset scenarios.
module tb_miniproc_control;

  typedef struct {
    logic [1:0] adr;
    logic [3:0] data;
    logic       c;
  } wr_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  miniproc_control_if bus ();

  miniproc_control dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  logic [1:0] imem [8];
  logic [3:0] dmem [4];
  logic       tb_wr;
  logic [1:0] tb_wr_adr;
  logic [3:0] tb_wr_data;
  int         wr_count = 0;
  int         cyc = 0;

  assign bus.out_a = dmem[bus.adr_r_a];
  assign bus.out_b = dmem[bus.adr_r_b];

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (!bus.i_w_e_n) imem[bus.i_adr] <= bus.i_data_w;
    bus.i_out <= imem[bus.i_adr];
    if (!bus.d_w_e_n) begin
      dmem[bus.adr_w] <= bus.data_w;
      wr_count        <= wr_count + 1;
    end else if (tb_wr) begin
      dmem[tb_wr_adr] <= tb_wr_data;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  wr_t exp_q[$];
  int  run_id = 0;
  int  mon_run = 0;
  int  last_exec = -1;
  bit  carry_pend = 0;
  bit  carry_exp = 0;

  // Scoreboard: every data memory write is popped against the model.
  always @(negedge clock) begin
    wr_t e;
    if (mon_run != run_id) begin
      mon_run   = run_id;
      last_exec = -1;
    end
    if (carry_pend) begin
      chk("carry", int'(bus.carry), int'(carry_exp));
      carry_pend = 0;
    end
    if (bus.d_w_e_n === 1'b0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("wr_adr", int'(bus.adr_w), int'(e.adr));
        chk("wr_data", int'(bus.data_w), int'(e.data));
        carry_exp  = e.c;
        carry_pend = 1;
        if (last_exec >= 0) chk("exec_gap", cyc - last_exec, 3);
        last_exec = cyc;
      end
    end
  end

  int m_r [4];
  bit m_c = 0;

  task automatic push_wr(input int adr, input int data, input bit c);
    wr_t e;
    e.adr  = 2'(adr);
    e.data = 4'(data);
    e.c    = c;
    exp_q.push_back(e);
  endtask

  task automatic set_reg(input int adr, input int val);
    @(negedge clock);
    tb_wr      = 1'b1;
    tb_wr_adr  = 2'(adr);
    tb_wr_data = 4'(val);
    @(negedge clock);
    tb_wr = 1'b0;
  endtask

  task automatic load_prog(input logic [1:0] p [8], input int n, input bit with_start);
    @(negedge clock);
    bus.load = 1'b1;
    if (with_start) bus.start = 1'b1;
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      bus.start = 1'b0;
      chk("ld_wen", int'(bus.i_w_e_n), 0);
      chk("ld_adr", int'(bus.i_adr), k);
      chk("ld_busy", int'(bus.busy), 0);
      bus.load_data = p[k];
      if (k == n - 1) bus.load = 1'b0;
    end
    @(negedge clock);
    chk("ld_exit_wen", int'(bus.i_w_e_n), 1);
    chk("ld_exit_busy", int'(bus.busy), 0);
    for (int k = 0; k < n; k++) chk("imem", int'(imem[k]), int'(p[k]));
  endtask

  task automatic run_prog(input logic [1:0] p [8], input int r1, input int r2, input int r3);
    int hpc;
    int s;
    hpc = 8;
    for (int i = 7; i >= 0; i--) if (p[i] == 2'b11) hpc = i;
    m_r[1] = r1; m_r[2] = r2; m_r[3] = r3;
    for (int i = 0; i < hpc; i++) begin
      case (p[i])
        2'b00: begin
          s = m_r[1] + m_r[2];
          m_r[3] = s % 16;
          m_c = (s > 15);
          push_wr(3, m_r[3], m_c);
        end
        2'b01: begin
          s = m_r[1] - m_r[2];
          m_r[3] = (s + 16) % 16;
          m_c = (m_r[1] < m_r[2]);
          push_wr(3, m_r[3], m_c);
        end
        default: begin
          m_r[1] = m_r[3];
          push_wr(1, m_r[1], m_c);
        end
      endcase
    end
    set_reg(1, r1); set_reg(2, r2); set_reg(3, r3);
    run_id++;
    @(negedge clock) bus.start = 1'b1;
    @(negedge clock) bus.start = 1'b0;
    for (int t = 0; t < 100 && !bus.done; t++) @(negedge clock);
    chk("halt_done", int'(bus.done), 1);
    chk("halt_pc", int'(bus.pc), hpc);
    chk("halt_busy", int'(bus.busy), 0);
    chk("sb_empty", exp_q.size(), 0);
    chk("r1_final", int'(dmem[1]), m_r[1]);
    chk("r3_final", int'(dmem[3]), m_r[3]);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] prog [8];
    int prev_pc, bad_busy, saw_done, wc;
    bit saw_wrap;

    reset = 1'b1;
    bus.load = 1'b0;
    bus.start = 1'b0;
    bus.load_data = 2'b00;
    tb_wr = 1'b0;
    tb_wr_adr = 2'b00;
    tb_wr_data = 4'h0;
    repeat (3) @(negedge clock);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_dwen", int'(bus.d_w_e_n), 1);
    chk("rst_iwen", int'(bus.i_w_e_n), 1);
    chk("rst_pc", int'(bus.pc), 0);
    chk("rst_carry", int'(bus.carry), 0);
    chk("rst_iadr", int'(bus.i_adr), 0);
    chk("rst_idata", int'(bus.i_data_w), 0);
    chk("rst_radr", int'({bus.adr_r_a, bus.adr_r_b}), 0);
    chk("rst_wadr", int'(bus.adr_w), 0);
    chk("rst_wdata", int'(bus.data_w), 0);
    reset = 1'b0;
    m_c = 0;

    prog = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00};
    load_prog(prog, 4, 1'b0);
    run_prog(prog, 5, 3, 0);

    prog = '{2'b00, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    load_prog(prog, 3, 1'b0);
    run_prog(prog, 9, 8, 0);

    prog = '{2'b01, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    load_prog(prog, 2, 1'b0);
    run_prog(prog, 2, 5, 0);

    // Eight MOVs: pc wraps, no halt; a start/load pulse mid-run is ignored.
    prog = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
    load_prog(prog, 8, 1'b0);
    set_reg(1, 0); set_reg(2, 0); set_reg(3, 6);
    for (int i = 0; i < 9; i++) push_wr(1, 6, m_c);
    run_id++;
    @(negedge clock) bus.start = 1'b1;
    saw_wrap = 0; bad_busy = 0; saw_done = 0; prev_pc = 0;
    for (int c = 1; c <= 27; c++) begin
      @(negedge clock);
      bus.start = 1'b0;
      bus.load  = 1'b0;
      if (!bus.busy) bad_busy++;
      if (bus.done) saw_done++;
      if (prev_pc == 7 && bus.pc == 0) saw_wrap = 1;
      prev_pc = int'(bus.pc);
      if (c == 10) begin
        bus.start = 1'b1;
        bus.load  = 1'b1;
      end
    end
    @(negedge clock);
    chk("wrap_not_busy", bad_busy, 0);
    chk("wrap_done", saw_done, 0);
    chk("wrap_seen", int'(saw_wrap), 1);
    chk("wrap_sb_empty", exp_q.size(), 0);

    // Reset raised inside an EXEC cycle must not let that write land.
    @(negedge clock);
    @(posedge clock);
    #2 reset = 1'b1;
    wc = wr_count;
    @(negedge clock);
    chk("rst_exec_radr", int'(bus.adr_r_a), 3);
    chk("rst_exec_dwen", int'(bus.d_w_e_n), 1);
    @(negedge clock);
    chk("rst_exec_nowr", wr_count, wc);
    chk("rst_exec_busy", int'(bus.busy), 0);
    chk("rst_exec_pc", int'(bus.pc), 0);
    chk("rst_exec_done", int'(bus.done), 0);
    reset = 1'b0;
    m_c = 0;

    // load wins over a simultaneous start in IDLE.
    prog = '{2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    load_prog(prog, 2, 1'b1);
    chk("ld_start_pc", int'(bus.pc), 0);
    chk("ld_start_wr", wr_count, wc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
